id_stage: RTL and testbench

- Instruction-decode stage of the 5-stage MIPS pipeline, and the consumer of the fetch stage's IFtoID_PC / IFtoID_inst outputs.
- Contains the IF/ID pipeline register, the 32x32 register file, main control decode, load-use and branch hazard detection, branch/jump resolution, and the ID/EX pipeline register.
- Drives PCWrite, PCSrc and the 32-bit branch/jump target back to the fetch stage.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/register_file.sv | 38 +++
 rtl/id_stage.sv | 150 +++++++++++++++
 tb/tb_id_stage.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcode, ALUOp and control-word definitions shared by the decode stage
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/register_file.sv
// rtl/register_file.sv - 32-entry register file, r0 hardwired to zero, write-first read bypass
module register_file #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] i_ra1,
  input  logic [REG_AW-1:0] i_ra2,
  output logic [DATA_W-1:0] o_rd1,
  output logic [DATA_W-1:0] o_rd2,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_wa,
  input  logic [DATA_W-1:0] i_wd
);

  logic [DATA_W-1:0] r_mem [2**REG_AW];
  logic              w_wr_ok;

  assign w_wr_ok = i_we && (i_wa != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**REG_AW; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  // A write landing this cycle is visible to the same-cycle read.
  always_comb begin
    o_rd1 = '0;
    o_rd2 = '0;
    if (i_ra1 != '0) o_rd1 = (w_wr_ok && i_wa == i_ra1) ? i_wd : r_mem[i_ra1];
    if (i_ra2 != '0) o_rd2 = (w_wr_ok && i_wa == i_ra2) ? i_wd : r_mem[i_ra2];
  end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - MIPS decode stage: IF/ID and ID/EX registers, decode, hazards, branch resolve
module id_stage
  import mips_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter int          REG_AW   = 5,
  parameter logic [31:0] NOP_INST = mips_pkg::NOP_INST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] IFtoID_PC,
  input  logic [DATA_W-1:0] IFtoID_inst,
  input  logic              WB_RegWrite,
  input  logic [REG_AW-1:0] WB_WriteReg,
  input  logic [DATA_W-1:0] WB_WriteData,
  input  logic              EX_MemRead,
  input  logic              EX_RegWrite,
  input  logic [REG_AW-1:0] EX_WriteReg,
  input  logic              MEM_MemRead,
  input  logic [REG_AW-1:0] MEM_WriteReg,
  output logic              PCWrite,
  output logic              PCSrc,
  output logic [DATA_W-1:0] ID_Target,
  output logic [DATA_W-1:0] IDtoEX_PC,
  output logic [DATA_W-1:0] IDtoEX_RD1,
  output logic [DATA_W-1:0] IDtoEX_RD2,
  output logic [DATA_W-1:0] IDtoEX_Imm,
  output logic [REG_AW-1:0] IDtoEX_Rs,
  output logic [REG_AW-1:0] IDtoEX_Rt,
  output logic [REG_AW-1:0] IDtoEX_Rd,
  output logic              IDtoEX_RegWrite,
  output logic              IDtoEX_MemtoReg,
  output logic              IDtoEX_MemRead,
  output logic              IDtoEX_MemWrite,
  output logic              IDtoEX_ALUSrc,
  output logic              IDtoEX_RegDst,
  output logic [1:0]        IDtoEX_ALUOp
);

  logic [DATA_W-1:0] r_if_pc, r_if_inst;
  logic [5:0]        w_op;
  logic [REG_AW-1:0] w_rs, w_rt, w_rd;
  logic [DATA_W-1:0] w_rd1, w_rd2, w_imm, w_br_target, w_j_target;
  logic              w_is_beq, w_is_bne, w_is_br, w_is_j, w_reads_rt;
  logic              w_load_use, w_br_dep, w_stall, w_taken, w_flush;
  ctrl_t             w_ctrl, r_ctrl;

  assign w_op  = r_if_inst[31:26];
  assign w_rs  = r_if_inst[25:21];
  assign w_rt  = r_if_inst[20:16];
  assign w_rd  = r_if_inst[15:11];
  assign w_imm = {{(DATA_W-16){r_if_inst[15]}}, r_if_inst[15:0]};

  register_file #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rf (
    .clk   (clk),
    .rst   (rst),
    .i_ra1 (w_rs),
    .i_ra2 (w_rt),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2),
    .i_we  (WB_RegWrite),
    .i_wa  (WB_WriteReg),
    .i_wd  (WB_WriteData)
  );

  always_comb begin
    w_ctrl = '0;
    case (w_op)
      OP_RTYPE: begin w_ctrl.reg_write = 1'b1; w_ctrl.reg_dst = 1'b1; w_ctrl.alu_op = ALUOP_RTYPE; end
      OP_LW: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_read   = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.alu_op     = ALUOP_ADD;
      end
      OP_SW:   begin w_ctrl.mem_write = 1'b1; w_ctrl.alu_src = 1'b1; w_ctrl.alu_op = ALUOP_ADD; end
      OP_ADDI: begin w_ctrl.reg_write = 1'b1; w_ctrl.alu_src = 1'b1; w_ctrl.alu_op = ALUOP_ADD; end
      OP_BEQ, OP_BNE: w_ctrl.alu_op = ALUOP_SUB;
      default: w_ctrl = '0;
    endcase
  end

  assign w_is_beq   = (w_op == OP_BEQ);
  assign w_is_bne   = (w_op == OP_BNE);
  assign w_is_br    = w_is_beq || w_is_bne;
  assign w_is_j     = (w_op == OP_J);
  assign w_reads_rt = (w_op == OP_RTYPE) || (w_op == OP_SW) || w_is_br;

  assign w_load_use = EX_MemRead && (EX_WriteReg != '0) &&
                      ((EX_WriteReg == w_rs) || (w_reads_rt && EX_WriteReg == w_rt));
  // Branches compare in ID, so any producer still in EX, or a load still in MEM, is too late to bypass.
  assign w_br_dep   = w_is_br &&
                      ((EX_RegWrite && (EX_WriteReg != '0) && (EX_WriteReg == w_rs || EX_WriteReg == w_rt)) ||
                       (MEM_MemRead && (MEM_WriteReg != '0) && (MEM_WriteReg == w_rs || MEM_WriteReg == w_rt)));
  assign w_stall    = w_load_use || w_br_dep;

  assign w_taken     = (w_is_beq && (w_rd1 == w_rd2)) || (w_is_bne && (w_rd1 != w_rd2)) || w_is_j;
  assign w_flush     = !rst && !w_stall && w_taken;
  assign w_br_target = r_if_pc + (w_imm << 2);
  assign w_j_target  = {r_if_pc[DATA_W-1:DATA_W-4], r_if_inst[25:0], 2'b00};

  assign PCWrite   = !rst && !w_stall;
  assign PCSrc     = w_flush;
  assign ID_Target = w_is_j ? w_j_target : w_br_target;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_pc   <= '0;
      r_if_inst <= NOP_INST;
    end else if (w_flush) begin
      r_if_pc   <= IFtoID_PC;
      r_if_inst <= NOP_INST;
    end else if (!w_stall) begin
      r_if_pc   <= IFtoID_PC;
      r_if_inst <= IFtoID_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_stall) begin
      IDtoEX_PC  <= '0;
      IDtoEX_RD1 <= '0;
      IDtoEX_RD2 <= '0;
      IDtoEX_Imm <= '0;
      IDtoEX_Rs  <= '0;
      IDtoEX_Rt  <= '0;
      IDtoEX_Rd  <= '0;
      r_ctrl     <= '0;
    end else begin
      IDtoEX_PC  <= r_if_pc;
      IDtoEX_RD1 <= w_rd1;
      IDtoEX_RD2 <= w_rd2;
      IDtoEX_Imm <= w_imm;
      IDtoEX_Rs  <= w_rs;
      IDtoEX_Rt  <= w_rt;
      IDtoEX_Rd  <= w_rd;
      r_ctrl     <= w_ctrl;
    end
  end

  assign IDtoEX_RegWrite = r_ctrl.reg_write;
  assign IDtoEX_MemtoReg = r_ctrl.mem_to_reg;
  assign IDtoEX_MemRead  = r_ctrl.mem_read;
  assign IDtoEX_MemWrite = r_ctrl.mem_write;
  assign IDtoEX_ALUSrc   = r_ctrl.alu_src;
  assign IDtoEX_RegDst   = r_ctrl.reg_dst;
  assign IDtoEX_ALUOp    = r_ctrl.alu_op;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - self-checking bench for id_stage with a behavioural pipeline model
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IFtoID_PC, IFtoID_inst;
  logic        WB_RegWrite;
  logic [4:0]  WB_WriteReg;
  logic [31:0] WB_WriteData;
  logic        EX_MemRead, EX_RegWrite, MEM_MemRead;
  logic [4:0]  EX_WriteReg, MEM_WriteReg;
  logic        PCWrite, PCSrc;
  logic [31:0] ID_Target, IDtoEX_PC, IDtoEX_RD1, IDtoEX_RD2, IDtoEX_Imm;
  logic [4:0]  IDtoEX_Rs, IDtoEX_Rt, IDtoEX_Rd;
  logic        IDtoEX_RegWrite, IDtoEX_MemtoReg, IDtoEX_MemRead, IDtoEX_MemWrite;
  logic        IDtoEX_ALUSrc, IDtoEX_RegDst;
  logic [1:0]  IDtoEX_ALUOp;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst), .IFtoID_PC(IFtoID_PC), .IFtoID_inst(IFtoID_inst),
    .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg), .WB_WriteData(WB_WriteData),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_WriteReg(EX_WriteReg),
    .MEM_MemRead(MEM_MemRead), .MEM_WriteReg(MEM_WriteReg),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .ID_Target(ID_Target),
    .IDtoEX_PC(IDtoEX_PC), .IDtoEX_RD1(IDtoEX_RD1), .IDtoEX_RD2(IDtoEX_RD2), .IDtoEX_Imm(IDtoEX_Imm),
    .IDtoEX_Rs(IDtoEX_Rs), .IDtoEX_Rt(IDtoEX_Rt), .IDtoEX_Rd(IDtoEX_Rd),
    .IDtoEX_RegWrite(IDtoEX_RegWrite), .IDtoEX_MemtoReg(IDtoEX_MemtoReg),
    .IDtoEX_MemRead(IDtoEX_MemRead), .IDtoEX_MemWrite(IDtoEX_MemWrite),
    .IDtoEX_ALUSrc(IDtoEX_ALUSrc), .IDtoEX_RegDst(IDtoEX_RegDst), .IDtoEX_ALUOp(IDtoEX_ALUOp)
  );

  typedef struct packed {
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic [7:0]  ctrl;   // {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, RegDst, ALUOp}
  } idex_t;

  typedef struct {
    logic [31:0] inst;
    logic [7:0]  ctrl;
  } dec_vec_t;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_pc, m_inst;
  idex_t       m_ex, e_next;
  logic        e_stall, e_flush, e_pcwrite;
  logic [31:0] e_target;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ctrl_of(input logic [5:0] op);
    case (op)
      6'h00:        return 8'b1000_0110;
      6'h23:        return 8'b1110_1000;
      6'h2B:        return 8'b0001_1000;
      6'h08:        return 8'b1000_1000;
      6'h04, 6'h05: return 8'b0000_0001;
      default:      return 8'b0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] rdreg(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (WB_RegWrite && WB_WriteReg == a) return WB_WriteData;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'h00, 6'h20};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic model_comb();
    logic [5:0]  op;
    logic [4:0]  rs, rt;
    logic [31:0] a, b, simm;
    logic        br, rrt, lu, bd, take;
    op   = m_inst[31:26];
    rs   = m_inst[25:21];
    rt   = m_inst[20:16];
    br   = (op == 6'h04) || (op == 6'h05);
    rrt  = (op == 6'h00) || (op == 6'h2B) || br;
    lu   = EX_MemRead && EX_WriteReg != 0 && (EX_WriteReg == rs || (rrt && EX_WriteReg == rt));
    bd   = br && ((EX_RegWrite && EX_WriteReg != 0 && (EX_WriteReg == rs || EX_WriteReg == rt)) ||
                  (MEM_MemRead && MEM_WriteReg != 0 && (MEM_WriteReg == rs || MEM_WriteReg == rt)));
    a    = rdreg(rs);
    b    = rdreg(rt);
    simm = {{16{m_inst[15]}}, m_inst[15:0]};
    take = (op == 6'h04 && a == b) || (op == 6'h05 && a != b) || (op == 6'h02);
    e_stall   = lu || bd;
    e_flush   = !rst && !e_stall && take;
    e_pcwrite = !rst && !e_stall;
    e_target  = (op == 6'h02) ? {m_pc[31:28], m_inst[25:0], 2'b00} : m_pc + simm * 4;
    e_next.pc   = m_pc;
    e_next.rd1  = a;
    e_next.rd2  = b;
    e_next.imm  = simm;
    e_next.rs   = rs;
    e_next.rt   = rt;
    e_next.rd   = m_inst[15:11];
    e_next.ctrl = ctrl_of(op);
  endtask

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_pc = 0; m_inst = 0; m_ex = '0;
    end else begin
      if (WB_RegWrite && WB_WriteReg != 0) m_regs[WB_WriteReg] = WB_WriteData;
      m_ex = e_stall ? '0 : e_next;
      if (e_flush) begin m_inst = 32'h0; m_pc = IFtoID_PC; end
      else if (!e_stall) begin m_inst = IFtoID_inst; m_pc = IFtoID_PC; end
    end
  endtask

  task automatic step();
    #1;
    model_comb();
    chk("pcwrite", 32'(PCWrite), 32'(e_pcwrite));
    chk("pcsrc", 32'(PCSrc), 32'(e_flush));
    if (!rst) chk("target", ID_Target, e_target);
    @(posedge clk);
    model_edge();
    #1;
    chk("idex_pc", IDtoEX_PC, m_ex.pc);
    chk("idex_rd1", IDtoEX_RD1, m_ex.rd1);
    chk("idex_rd2", IDtoEX_RD2, m_ex.rd2);
    chk("idex_imm", IDtoEX_Imm, m_ex.imm);
    chk("idex_fields", 32'({IDtoEX_Rs, IDtoEX_Rt, IDtoEX_Rd, ctrl_now()}),
        32'({m_ex.rs, m_ex.rt, m_ex.rd, m_ex.ctrl}));
  endtask

  function automatic logic [7:0] ctrl_now();
    return {IDtoEX_RegWrite, IDtoEX_MemtoReg, IDtoEX_MemRead, IDtoEX_MemWrite,
            IDtoEX_ALUSrc, IDtoEX_RegDst, IDtoEX_ALUOp};
  endfunction

  task automatic clear_side();
    WB_RegWrite = 0; WB_WriteReg = 0; WB_WriteData = 0;
    EX_MemRead = 0; EX_RegWrite = 0; EX_WriteReg = 0;
    MEM_MemRead = 0; MEM_WriteReg = 0;
  endtask

  dec_vec_t dec_tab [8];
  logic [5:0] op_pool [8];

  initial begin
    m_ex = '0; m_pc = 0; m_inst = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    rst = 1; IFtoID_PC = 0; IFtoID_inst = 0;
    clear_side();

    // Reset held for two edges
    step(); step();
    #1;
    chk("reset_pcwrite", 32'(PCWrite), 32'h0);
    chk("reset_idex_ctrl", 32'(ctrl_now()), 32'h0);
    chk("reset_idex_pc_rd", IDtoEX_PC | IDtoEX_RD1 | IDtoEX_RD2, 32'h0);
    rst = 0;
    IFtoID_inst = rtype(5, 5, 6); IFtoID_PC = 32'h4;
    #1 chk("release_pcwrite", 32'(PCWrite), 32'h1);
    step();
    IFtoID_inst = 0;
    step();
    chk("r5_reads_zero", IDtoEX_RD1, 32'h0);

    // Decode table
    dec_tab[0] = '{rtype(1, 2, 3),                 8'b1000_0110};
    dec_tab[1] = '{itype(6'h23, 1, 2, 16'h0010),   8'b1110_1000};
    dec_tab[2] = '{itype(6'h2B, 1, 2, 16'h0010),   8'b0001_1000};
    dec_tab[3] = '{itype(6'h08, 1, 2, 16'h8000),   8'b1000_1000};
    dec_tab[4] = '{itype(6'h04, 0, 0, 16'h0003),   8'b0000_0001};
    dec_tab[5] = '{itype(6'h05, 0, 0, 16'h0003),   8'b0000_0001};
    dec_tab[6] = '{32'h0800_1234,                  8'b0000_0000};
    dec_tab[7] = '{itype(6'h3F, 1, 2, 16'hFFFF),   8'b0000_0000};
    for (int i = 0; i < 8; i++) begin
      IFtoID_inst = dec_tab[i].inst; IFtoID_PC = 32'h40 + 32'(i * 4);
      step();
      IFtoID_inst = 0;
      step();
      chk($sformatf("decode_%0d", i), 32'(ctrl_now()), 32'(dec_tab[i].ctrl));
    end

    // Write-first bypass, then a write to r0
    IFtoID_inst = rtype(3, 3, 1);
    step();
    IFtoID_inst = 0;
    WB_RegWrite = 1; WB_WriteReg = 3; WB_WriteData = 32'hDEAD_BEEF;
    step();
    chk("bypass_rd1", IDtoEX_RD1, 32'hDEAD_BEEF);
    chk("bypass_rd2", IDtoEX_RD2, 32'hDEAD_BEEF);
    clear_side();
    IFtoID_inst = rtype(0, 0, 1);
    step();
    IFtoID_inst = 0;
    WB_RegWrite = 1; WB_WriteReg = 0; WB_WriteData = 32'h1234_5678;
    step();
    chk("r0_write_dropped", IDtoEX_RD1, 32'h0);
    clear_side();

    // Load-use: one bubble then the add issues
    IFtoID_inst = rtype(2, 1, 4);
    step();
    IFtoID_inst = 0;
    EX_MemRead = 1; EX_WriteReg = 2;
    #1 chk("loaduse_pcwrite", 32'(PCWrite), 32'h0);
    step();
    chk("loaduse_bubble", 32'(ctrl_now()), 32'h0);
    clear_side();
    #1 chk("loaduse_resume", 32'(PCWrite), 32'h1);
    step();
    chk("loaduse_add_ctrl", 32'({IDtoEX_RegWrite, IDtoEX_RegDst, IDtoEX_ALUOp}), 32'b1110);

    // beq taken
    WB_RegWrite = 1; WB_WriteReg = 1; WB_WriteData = 7;
    step();
    WB_WriteReg = 2;
    IFtoID_PC = 32'h100; IFtoID_inst = itype(6'h04, 1, 2, 16'hFFFE);
    step();
    clear_side();
    IFtoID_PC = 32'h104; IFtoID_inst = rtype(3, 3, 1);
    #1;
    chk("beq_pcsrc", 32'(PCSrc), 32'h1);
    chk("beq_target", ID_Target, 32'h0000_00F8);
    step();
    IFtoID_inst = 0;
    #1 chk("beq_squash_pcsrc", 32'(PCSrc), 32'h0);
    step();
    chk("beq_squash_imm", IDtoEX_Imm, 32'h0);

    // bne not taken, then the same bne behind an EX producer
    IFtoID_PC = 32'h200; IFtoID_inst = itype(6'h05, 1, 2, 16'h0004);
    step();
    #1;
    chk("bne_nt_pcsrc", 32'(PCSrc), 32'h0);
    chk("bne_nt_pcwrite", 32'(PCWrite), 32'h1);
    chk("bne_nt_target", ID_Target, 32'h0000_0210);
    step();
    EX_RegWrite = 1; EX_WriteReg = 1;
    IFtoID_inst = 0;
    #1 chk("bne_dep_pcwrite", 32'(PCWrite), 32'h0);
    step();
    clear_side();
    #1;
    chk("bne_resolve_pcwrite", 32'(PCWrite), 32'h1);
    chk("bne_resolve_pcsrc", 32'(PCSrc), 32'h0);
    step();

    // Jump
    IFtoID_PC = 32'h8000_0010; IFtoID_inst = 32'h0800_0040;
    step();
    IFtoID_inst = 0;
    #1;
    chk("j_target", ID_Target, 32'h8000_0100);
    chk("j_pcsrc", 32'(PCSrc), 32'h1);
    step();

    // Reset during a load-use stall
    IFtoID_inst = rtype(2, 1, 4); IFtoID_PC = 32'h2F0;
    step();
    EX_MemRead = 1; EX_WriteReg = 2;
    #1 chk("rststall_pcwrite", 32'(PCWrite), 32'h0);
    rst = 1;
    step();
    rst = 0;
    clear_side();
    IFtoID_PC = 32'h300; IFtoID_inst = rtype(3, 3, 1);
    #1;
    chk("rststall_idex", 32'({IDtoEX_Rs, IDtoEX_Rt, IDtoEX_Rd, ctrl_now()}), 32'h0);
    chk("rststall_ifid_target", ID_Target, 32'h0);
    chk("rststall_pcwrite_after", 32'(PCWrite), 32'h1);
    step();

    // Randomized traffic against the model
    op_pool = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h05, 6'h02, 6'h3F};
    for (int n = 0; n < 600; n++) begin
      rst          = ($urandom_range(0, 63) == 0);
      IFtoID_PC    = $urandom & 32'hFFFF_FFFC;
      IFtoID_inst  = {op_pool[$urandom_range(0, 7)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      16'($urandom)};
      WB_RegWrite  = 1'($urandom_range(0, 1));
      WB_WriteReg  = 5'($urandom_range(0, 7));
      WB_WriteData = $urandom;
      EX_MemRead   = ($urandom_range(0, 3) == 0);
      EX_RegWrite  = 1'($urandom_range(0, 1));
      EX_WriteReg  = 5'($urandom_range(0, 7));
      MEM_MemRead  = ($urandom_range(0, 3) == 0);
      MEM_WriteReg = 5'($urandom_range(0, 7));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
